numitron_shift_driver: RTL and testbench
========================================

Name: numitron_shift_driver

Overview:
- Sits directly downstream of the per-digit hex-to-7-segment decoders in the Numitron clock.
- Captures one frame of segment patterns (DIGITS x 7 segments plus decimal points) through a valid/ready handshake.
- Serialises the frame into the 74HC595-style shift-register chain driving the IV-16 filaments, then pulses the latch.
- Generates a PWM output-enable for brightness control.

Parameters:
- DIGITS, 4, number of tubes; each tube uses one 8-bit shift-register byte.
- DIV, 4, clk cycles per sr_clk half-period; legal range >=1.
- LATCH_W, 2, clk cycles sr_latch is held high; legal range >=1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_data  in  7*DIGITS  segment patterns; bits [7d+6:7d] = digit d, bit 0 of each = segment a.
- dp  in  DIGITS  decimal point per digit; dp[d] belongs to digit d.
- load_valid  in  1  frame offered.
- load_ready  out  1  block can accept a frame.
- bright  in  4  brightness, 0 = off, 15 = 15/16 duty.
- sr_clk  out  1  shift clock to the chain.
- sr_data  out  1  serial data to the chain.
- sr_latch  out  1  storage-register latch pulse.
- sr_oe_n  out  1  active-low output enable to the chain.
- busy  out  1  high from the cycle after accept until return to IDLE.

Behaviour:
- Reset values (async, all outputs registered):
  - sr_clk=0, sr_data=0, sr_latch=0, sr_oe_n=1, busy=0, load_ready=1.
  - State=IDLE, shadow frame=0, pwm_cnt=0, frame_valid flag=0.
- States: IDLE -> SHIFT -> LATCH -> IDLE.
- IDLE:
  - load_ready=1.
  - Accept when load_valid & load_ready at edge T0: the frame is captured into a shadow register.
  - At T0+1: state=SHIFT, load_ready=0, busy=1.
- Frame format: NB = 8*DIGITS bits.
  - Byte per digit = {dp[d], seg_data[7d+6:7d]}.
  - Digit DIGITS-1 is shifted first, digit 0 last.
  - Within a byte, MSB (dp) first, seg a last.
- SHIFT, bit k (k = 0..NB-1):
  - sr_data is updated at the start of the low phase.
  - sr_clk is low for DIV cycles starting at T0+1+2k*DIV, then high for DIV cycles.
  - sr_data is stable throughout the high phase.
  - After the high phase of bit NB-1, sr_clk returns to 0 and state=LATCH.
- LATCH:
  - sr_latch=1 for cycles T0+2*DIV*NB+1 .. T0+2*DIV*NB+LATCH_W, with sr_clk=0.
  - Then IDLE: load_ready=1 and busy=0 at T0+2*DIV*NB+LATCH_W+1.
  - The first completed latch sets frame_valid.
- Defaults (DIGITS=4, DIV=4, LATCH_W=2): latch high at T0+257..258; ready at T0+259.
- Changes to seg_data/dp after accept have no effect on the frame in flight.
- load_valid while not ready is ignored: no capture, no queueing.
- PWM:
  - 4-bit pwm_cnt increments every clk and wraps 15->0.
  - bright is sampled when pwm_cnt==0.
  - sr_oe_n = ~(frame_valid & (pwm_cnt < bright_sampled)), registered (1-cycle delay).
  - bright=0 keeps sr_oe_n=1 permanently.
  - bright=15 gives 15 low cycles per 16.
- sr_oe_n stays 1 until frame_valid, so power-up garbage in the chain is never displayed.
- Reset mid-SHIFT or mid-LATCH:
  - Aborts immediately; no latch pulse is produced.
  - frame_valid clears, so the display blanks until the next full frame is latched.
- Accept in the same cycle IDLE is re-entered is legal: a frame at T0+2*DIV*NB+LATCH_W+1 is accepted, giving back-to-back frames with no gap.

Test Plan:
- Reset release, bright=15, no load: sr_oe_n=1 forever, load_ready=1, sr_clk/sr_latch never toggle.
- Load seg_data={7'h06,7'h5B,7'h4F,7'h66} (digits 3..0 = "1","2","3","4"), dp=4'b0001, defaults: the 32 bits sampled on sr_clk rising edges equal 0x065B4FE6; sr_latch high at T0+257..258; load_ready high at T0+259.
- After the first frame, bright=8: sr_oe_n low exactly 8 of every 16 cycles. Then bright=0: sr_oe_n stuck at 1 from the next PWM period.
- Pulse load_valid at T0+10 and change seg_data at T0+5 during a shift: no second accept, shifted bits unchanged, a single latch pulse.
- Hold load_valid high continuously: frames accepted at T0 and T0+259; latch pulses exactly 259 cycles apart.
- Assert rst at T0+100 (mid-shift): all outputs return to reset values asynchronously, no latch pulse; after release, sr_oe_n=1 until a new frame is latched.

Source files
------------

// File: rtl/numitron_shift_driver.sv
// Serialises one frame of tube segment patterns into a 74HC595-style chain,
// pulses the storage latch, and drives a PWM output enable for brightness.
module numitron_shift_driver #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned DIV     = 4,
    parameter int unsigned LATCH_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7*DIGITS-1:0]   seg_data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [3:0]            bright,
    output logic                  sr_clk,
    output logic                  sr_data,
    output logic                  sr_latch,
    output logic                  sr_oe_n,
    output logic                  busy
);

    localparam int unsigned NB    = 8 * DIGITS;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = $clog2(NB);
    localparam int unsigned LAT_W = (LATCH_W > 1) ? $clog2(LATCH_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch
    } state_e;

    state_e           state_q;
    logic [NB-1:0]    frame;
    logic [NB-1:0]    shadow_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic             frame_valid_q;
    logic [3:0]       pwm_cnt_q;
    logic [3:0]       bright_q;
    logic [3:0]       bright_eff;

    // Pack digits into bytes {dp, seg g..a}; the top byte (last digit) goes out first.
    always_comb begin
        frame = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            frame[8*d +: 8] = {dp[d], seg_data[7*d +: 7]};
        end
    end

    // Handshake, shift sequencing and latch pulse; sr_clk doubles as the phase flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            shadow_q      <= '0;
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            lat_cnt_q     <= '0;
            frame_valid_q <= 1'b0;
            load_ready    <= 1'b1;
            busy          <= 1'b0;
            sr_clk        <= 1'b0;
            sr_data       <= 1'b0;
            sr_latch      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_valid && load_ready) begin
                        shadow_q   <= frame;
                        sr_data    <= frame[NB-1];
                        sr_clk     <= 1'b0;
                        div_cnt_q  <= '0;
                        bit_cnt_q  <= '0;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        if (!sr_clk) begin
                            sr_clk <= 1'b1;
                        end else begin
                            sr_clk <= 1'b0;
                            if (bit_cnt_q == BIT_LAST) begin
                                sr_latch  <= 1'b1;
                                lat_cnt_q <= '0;
                                state_q   <= StLatch;
                            end else begin
                                // Next bit goes out at the start of its low phase.
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                shadow_q  <= {shadow_q[NB-2:0], 1'b0};
                                sr_data   <= shadow_q[NB-2];
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                StLatch: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        sr_latch      <= 1'b0;
                        frame_valid_q <= 1'b1;
                        load_ready    <= 1'b1;
                        busy          <= 1'b0;
                        state_q       <= StIdle;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // A new brightness takes effect from the first count of each PWM period.
    always_comb begin
        bright_eff = (pwm_cnt_q == 4'd0) ? bright : bright_q;
    end

    // Free-running PWM; display stays dark until a complete frame has been latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= 4'd0;
            bright_q  <= 4'd0;
            sr_oe_n   <= 1'b1;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
            if (pwm_cnt_q == 4'd0) begin
                bright_q <= bright;
            end
            sr_oe_n <= ~(frame_valid_q & (pwm_cnt_q < bright_eff));
        end
    end

endmodule

// File: tb/tb_numitron_shift_driver.sv
// Directed bench for numitron_shift_driver with default parameters.
module tb_numitron_shift_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] seg_data = '0;
    logic [3:0]  dp = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  bright = 4'd15;
    logic        sr_clk;
    logic        sr_data;
    logic        sr_latch;
    logic        sr_oe_n;
    logic        busy;

    int total = 0;
    int bad   = 0;

    numitron_shift_driver dut (
        .clk        (clk),
        .rst        (rst),
        .seg_data   (seg_data),
        .dp         (dp),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .bright     (bright),
        .sr_clk     (sr_clk),
        .sr_data    (sr_data),
        .sr_latch   (sr_latch),
        .sr_oe_n    (sr_oe_n),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Cycle counter and passive monitor of the serial outputs.
    int          cyc = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_lat = 1'b0;
    logic [31:0] sh_bits = '0;
    int          sh_cnt = 0;
    int          lat_cnt = 0;
    int          lat_rise = 0;
    int          lat_rise_prev = 0;
    int          lat_fall = 0;
    int          oe_low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sr_clk && !prev_sclk) begin
            sh_bits = {sh_bits[30:0], sr_data};
            sh_cnt  = sh_cnt + 1;
        end
        prev_sclk = sr_clk;
        if (sr_latch && !prev_lat) begin
            lat_rise_prev = lat_rise;
            lat_rise      = cyc;
            lat_cnt       = lat_cnt + 1;
        end
        if (!sr_latch && prev_lat) lat_fall = cyc;
        prev_lat = sr_latch;
        if (!sr_oe_n) oe_low = oe_low + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!load_ready && k < 800) begin
            step(1);
            k++;
        end
        check(tag, 32'(load_ready), 32'd1);
    endtask

    task automatic wait_latch(input int target, input string tag);
        int k = 0;
        while (lat_cnt < target && k < 800) begin
            step(1);
            k++;
        end
        check(tag, 32'(lat_cnt >= target), 32'd1);
    endtask

    // Offer one frame; returns the counter value seen in cycle T0+1.
    task automatic start_frame(input logic [27:0] s, input logic [3:0] d, input logic hold,
                               output int a);
        seg_data = s;
        dp       = d;
        wait_ready("ready_before_load");
        load_valid = 1'b1;
        step(1);
        a = cyc;
        if (!hold) load_valid = 1'b0;
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_sr_clk"}, 32'(sr_clk), 32'd0);
        check({tag, "_sr_data"}, 32'(sr_data), 32'd0);
        check({tag, "_sr_latch"}, 32'(sr_latch), 32'd0);
        check({tag, "_sr_oe_n"}, 32'(sr_oe_n), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    endtask

    localparam logic [27:0] SEG_1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
    localparam logic [27:0] SEG_5678 = {7'h6D, 7'h7D, 7'h07, 7'h7F};
    localparam logic [27:0] SEG_ALT  = {7'h00, 7'h7F, 7'h00, 7'h7F};

    initial begin
        int a;
        int s0;
        int l0;
        int o0;

        // Reset state and idle behaviour with no frame ever loaded.
        step(1);
        reset_values("in_reset");
        step(2);
        rst = 1'b0;
        o0 = oe_low;
        s0 = sh_cnt;
        step(40);
        check("idle_oe_never_low", 32'(oe_low - o0), 32'd0);
        check("idle_no_sr_clk", 32'(sh_cnt - s0), 32'd0);
        check("idle_no_latch", 32'(lat_cnt), 32'd0);
        check("idle_ready", 32'(load_ready), 32'd1);

        // First frame "1234" with dp on digit 0.
        s0 = sh_cnt;
        start_frame(SEG_1234, 4'b0001, 1'b0, a);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_not_ready", 32'(load_ready), 32'd0);
        wait_latch(1, "frame1_latch_timeout");
        check("frame1_bits", sh_bits, 32'h065B4FE6);
        check("frame1_bitcount", 32'(sh_cnt - s0), 32'd32);
        check("frame1_latch_rise", 32'(lat_rise - a), 32'd256);
        wait_ready("frame1_ready_timeout");
        check("frame1_ready_cycle", 32'(cyc - a), 32'd258);
        check("frame1_latch_fall", 32'(lat_fall - a), 32'd258);
        check("frame1_idle_busy", 32'(busy), 32'd0);

        // PWM duty at a few brightness levels.
        step(32);
        o0 = oe_low;
        step(16);
        check("pwm_bright15", 32'(oe_low - o0), 32'd15);
        bright = 4'd8;
        step(32);
        o0 = oe_low;
        step(16);
        check("pwm_bright8", 32'(oe_low - o0), 32'd8);
        bright = 4'd0;
        step(17);
        o0 = oe_low;
        step(32);
        check("pwm_bright0", 32'(oe_low - o0), 32'd0);
        bright = 4'd15;

        // Input changes and a stray load_valid during a shift must not disturb it.
        l0 = lat_cnt;
        start_frame(SEG_5678, 4'b0000, 1'b0, a);
        step(4);
        seg_data = SEG_ALT;
        dp       = 4'b1111;
        step(5);
        load_valid = 1'b1;
        step(1);
        load_valid = 1'b0;
        wait_latch(l0 + 1, "frame2_latch_timeout");
        check("frame2_bits_unchanged", sh_bits, 32'h6D7D077F);
        check("frame2_latch_rise", 32'(lat_rise - a), 32'd256);
        wait_ready("frame2_ready_timeout");
        step(300);
        check("frame2_single_latch", 32'(lat_cnt - l0), 32'd1);
        check("frame2_no_queued_busy", 32'(busy), 32'd0);

        // Back-to-back frames while load_valid is held.
        l0 = lat_cnt;
        start_frame(SEG_1234, 4'b0001, 1'b1, a);
        wait_latch(l0 + 2, "b2b_latch_timeout");
        load_valid = 1'b0;
        check("b2b_first_latch", 32'(lat_rise_prev - a), 32'd256);
        check("b2b_latch_period", 32'(lat_rise - lat_rise_prev), 32'd259);
        check("b2b_bits", sh_bits, 32'h065B4FE6);
        wait_ready("b2b_ready_timeout");

        // Reset in the middle of a shift.
        l0 = lat_cnt;
        start_frame(SEG_5678, 4'b0000, 1'b0, a);
        step(99);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        reset_values("async_reset");
        step(3);
        rst = 1'b0;
        o0 = oe_low;
        step(300);
        check("post_reset_no_latch", 32'(lat_cnt - l0), 32'd0);
        check("post_reset_blank", 32'(oe_low - o0), 32'd0);
        check("post_reset_ready", 32'(load_ready), 32'd1);

        // Display comes back only after a fresh complete frame.
        s0 = sh_cnt;
        start_frame(SEG_5678, 4'b0000, 1'b0, a);
        wait_latch(l0 + 1, "frame3_latch_timeout");
        check("frame3_bits", sh_bits, 32'h6D7D077F);
        check("frame3_bitcount", 32'(sh_cnt - s0), 32'd32);
        wait_ready("frame3_ready_timeout");
        step(32);
        o0 = oe_low;
        step(16);
        check("frame3_pwm_on", 32'(oe_low - o0), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
